// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with valid/ready handshake,
// immediate generation sign-extended to XLEN, illegal-instruction
// detection and an optional skid entry that removes the out_ready to
// in_ready combinational path.
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic            out_uses_rs1,
  output logic            out_uses_rs2,
  output logic            out_writes_rd
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
  } entry_t;

  entry_t      dec;
  entry_t      out_q;
  entry_t      skid_q;
  logic        skid_valid;
  logic [31:0] imm32;
  logic        legal;
  logic        is_system;
  logic        in_fire;
  logic        out_free;

  // Decode the incoming fetch word into the full output record.
  always_comb begin
    dec        = '0;
    imm32      = '0;
    legal      = 1'b1;
    is_system  = 1'b0;
    dec.pc     = in_pc;
    dec.opcode = in_inst[6:0];
    dec.rd     = in_inst[11:7];
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.funct3 = in_inst[14:12];
    dec.funct7 = in_inst[31:25];
    dec.fmt    = FMT_I;
    case (in_inst[6:0])
      OPC_OP:                           dec.fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_MISC_MEM: dec.fmt = FMT_I;
      OPC_JALR: begin
        dec.fmt = FMT_I;
        if (in_inst[14:12] != 3'b000) legal = 1'b0;
      end
      OPC_SYSTEM: begin
        dec.fmt   = FMT_I;
        is_system = 1'b1;
      end
      OPC_STORE:                        dec.fmt = FMT_S;
      OPC_BRANCH: begin
        dec.fmt = FMT_B;
        if (in_inst[14:13] == 2'b01) legal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC:               dec.fmt = FMT_U;
      OPC_JAL:                          dec.fmt = FMT_J;
      default: begin
        dec.fmt = FMT_I;
        legal   = 1'b0;
      end
    endcase
    if (in_inst[1:0] != 2'b11) legal = 1'b0;
    case (dec.fmt)
      FMT_I:   imm32 = {{21{in_inst[31]}}, in_inst[30:20]};
      FMT_S:   imm32 = {{21{in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
      FMT_B:   imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      FMT_U:   imm32 = {in_inst[31:12], 12'b0};
      FMT_J:   imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
    dec.illegal   = !legal;
    dec.uses_rs1  = legal && !is_system &&
                    (dec.fmt == FMT_R || dec.fmt == FMT_I || dec.fmt == FMT_S || dec.fmt == FMT_B);
    dec.uses_rs2  = legal && (dec.fmt == FMT_R || dec.fmt == FMT_S || dec.fmt == FMT_B);
    dec.writes_rd = legal && !is_system && (dec.rd != 5'd0) &&
                    (dec.fmt == FMT_R || dec.fmt == FMT_I || dec.fmt == FMT_U || dec.fmt == FMT_J);
  end

  // With a skid entry, readiness depends only on local state so out_ready never reaches in_ready.
  assign in_ready = SKID ? (!reset && !skid_valid) : (!reset && (!out_valid || out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Output register and skid entry; flush beats every transfer, reset clears all state.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (SKID) begin
      if (out_free) begin
        if (skid_valid) begin
          out_q      <= skid_q;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (in_fire) begin
          out_q     <= dec;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
    end else begin
      if (out_free) begin
        if (in_fire) out_q <= dec;
        out_valid <= in_fire;
      end
    end
  end

  assign out_pc        = out_q.pc;
  assign out_opcode    = out_q.opcode;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_imm       = out_q.imm;
  assign out_fmt       = out_q.fmt;
  assign out_illegal   = out_q.illegal;
  assign out_uses_rs1  = out_q.uses_rs1;
  assign out_uses_rs2  = out_q.uses_rs2;
  assign out_writes_rd = out_q.writes_rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives two decode_stage instances (XLEN=32 with skid,
// XLEN=64 without skid) and compares them against a queue-based model.
module tb_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
  } obs_t;

  logic        clk;
  logic        reset;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] in_inst [2];
  logic [63:0] in_pc [2];
  logic        flush [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [6:0]  o_opcode [2];
  logic [4:0]  o_rd [2];
  logic [4:0]  o_rs1 [2];
  logic [4:0]  o_rs2 [2];
  logic [2:0]  o_funct3 [2];
  logic [6:0]  o_funct7 [2];
  logic [2:0]  o_fmt [2];
  logic        o_illegal [2];
  logic        o_uses_rs1 [2];
  logic        o_uses_rs2 [2];
  logic        o_writes_rd [2];
  logic [31:0] pc0;
  logic [31:0] imm0;
  logic [63:0] pc1;
  logic [63:0] imm1;
  obs_t        obs [2];

  int total;
  int bad;

  decode_stage #(.XLEN(32), .SKID(1'b1)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_inst(in_inst[0]), .in_pc(in_pc[0][31:0]),
    .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pc(pc0),
    .out_opcode(o_opcode[0]), .out_rd(o_rd[0]), .out_rs1(o_rs1[0]), .out_rs2(o_rs2[0]),
    .out_funct3(o_funct3[0]), .out_funct7(o_funct7[0]), .out_imm(imm0), .out_fmt(o_fmt[0]),
    .out_illegal(o_illegal[0]), .out_uses_rs1(o_uses_rs1[0]), .out_uses_rs2(o_uses_rs2[0]),
    .out_writes_rd(o_writes_rd[0])
  );

  decode_stage #(.XLEN(64), .SKID(1'b0)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_inst(in_inst[1]), .in_pc(in_pc[1]),
    .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pc(pc1),
    .out_opcode(o_opcode[1]), .out_rd(o_rd[1]), .out_rs1(o_rs1[1]), .out_rs2(o_rs2[1]),
    .out_funct3(o_funct3[1]), .out_funct7(o_funct7[1]), .out_imm(imm1), .out_fmt(o_fmt[1]),
    .out_illegal(o_illegal[1]), .out_uses_rs1(o_uses_rs1[1]), .out_uses_rs2(o_uses_rs2[1]),
    .out_writes_rd(o_writes_rd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gather each instance's outputs into one comparable record.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      obs[k]           = '0;
      obs[k].opcode    = o_opcode[k];
      obs[k].rd        = o_rd[k];
      obs[k].rs1       = o_rs1[k];
      obs[k].rs2       = o_rs2[k];
      obs[k].funct3    = o_funct3[k];
      obs[k].funct7    = o_funct7[k];
      obs[k].fmt       = o_fmt[k];
      obs[k].illegal   = o_illegal[k];
      obs[k].uses_rs1  = o_uses_rs1[k];
      obs[k].uses_rs2  = o_uses_rs2[k];
      obs[k].writes_rd = o_writes_rd[k];
    end
    obs[0].pc  = {32'b0, pc0};
    obs[0].imm = {32'b0, imm0};
    obs[1].pc  = pc1;
    obs[1].imm = imm1;
  end

  // Reference decode built from the instruction-set rules with signed arithmetic.
  function automatic obs_t model(input logic [31:0] inst, input logic [63:0] pc, input int xlen);
    obs_t   e;
    longint v;
    bit     legal;
    bit     sys;
    e = '0;
    legal = 1'b1;
    sys = 1'b0;
    e.pc = pc;
    e.opcode = inst[6:0];
    e.rd = inst[11:7];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.funct3 = inst[14:12];
    e.funct7 = inst[31:25];
    case (inst[6:0])
      7'b0110011: e.fmt = 3'd0;
      7'b0010011, 7'b0000011, 7'b0001111: e.fmt = 3'd1;
      7'b1100111: begin e.fmt = 3'd1; legal = (inst[14:12] == 3'd0); end
      7'b1110011: begin e.fmt = 3'd1; sys = 1'b1; end
      7'b0100011: e.fmt = 3'd2;
      7'b1100011: begin e.fmt = 3'd3; legal = !(inst[14:12] == 3'd2 || inst[14:12] == 3'd3); end
      7'b0110111, 7'b0010111: e.fmt = 3'd4;
      7'b1101111: e.fmt = 3'd5;
      default: begin e.fmt = 3'd1; legal = 1'b0; end
    endcase
    if (inst[1:0] != 2'b11) legal = 1'b0;
    case (e.fmt)
      3'd1: v = longint'($signed(inst[31:20]));
      3'd2: v = longint'($signed({inst[31:25], inst[11:7]}));
      3'd3: v = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      3'd4: v = longint'($signed(inst[31:12])) * 4096;
      3'd5: v = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: v = 0;
    endcase
    e.imm = v;
    if (xlen == 32) begin
      e.imm[63:32] = '0;
      e.pc[63:32] = '0;
    end
    e.illegal = !legal;
    e.uses_rs1 = legal && !sys && (e.fmt inside {3'd0, 3'd1, 3'd2, 3'd3});
    e.uses_rs2 = legal && (e.fmt inside {3'd0, 3'd2, 3'd3});
    e.writes_rd = legal && !sys && (e.rd != 5'd0) && (e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5});
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  ops [11];
    int          k;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    r = $urandom();
    k = $urandom_range(0, 13);
    if (k < 11) r[6:0] = ops[k];
    return r;
  endfunction

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    p = {$urandom(), $urandom()};
    p[1:0] = 2'b00;
    return p;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (in_ready[d] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_in_ready dut%0d: got %b want 0", d, in_ready[d]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || obs[d] !== '0) begin
        bad++;
        $display("[TB] FAIL reset_state dut%0d: got valid=%b ready=%b data=%h want valid=0 ready=1 data=0",
                 d, out_valid[d], in_ready[d], obs[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input int d, input logic [31:0] inst, input logic [63:0] pc,
                               input logic [63:0] exp_imm, input logic [2:0] exp_fmt,
                               input logic exp_ill);
    obs_t e;
    e = model(inst, pc, (d == 0) ? 32 : 64);
    in_valid[d] = 1'b1;
    in_inst[d] = inst;
    in_pc[d] = pc;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid[d] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL directed_valid %h: got %b want 1", inst, out_valid[d]);
    end
    total++;
    if (obs[d] !== e) begin
      bad++;
      $display("[TB] FAIL directed_fields %h: got %h want %h", inst, obs[d], e);
    end
    total++;
    if (obs[d].imm !== exp_imm || obs[d].fmt !== exp_fmt || obs[d].illegal !== exp_ill) begin
      bad++;
      $display("[TB] FAIL directed_const %h: got imm=%h fmt=%0d ill=%b want imm=%h fmt=%0d ill=%b",
               inst, obs[d].imm, obs[d].fmt, obs[d].illegal, exp_imm, exp_fmt, exp_ill);
    end
    @(posedge clk); #1;
  endtask

  // mode 0: four back-to-back words with a three-cycle stall once the first emerges; mode 1: random traffic.
  task automatic test_stream(input int d, input int mode, input int n);
    obs_t        q [$];
    logic [31:0] words [4];
    logic [31:0] inst;
    logic [63:0] pc;
    int          sent;
    int          got;
    int          cyc;
    bit          iv;
    bit          orr;
    bit          exp_rdy;
    int          xlen;
    xlen = (d == 0) ? 32 : 64;
    words = '{32'h00500093, 32'h00208133, 32'hFE21AC23, 32'h001000EF};
    sent = 0;
    got = 0;
    cyc = 0;
    while ((sent < n || q.size() > 0) && cyc < 2000) begin
      if (mode == 0) begin
        iv = (sent < n);
        orr = !(cyc >= 1 && cyc <= 3);
        inst = words[sent % 4];
        pc = 64'h200 + 64'(sent * 4);
      end else begin
        iv = (sent < n) && ($urandom_range(0, 3) != 0);
        orr = ($urandom_range(0, 2) != 0);
        inst = rand_inst();
        pc = rand_pc();
      end
      in_valid[d] = iv;
      in_inst[d] = inst;
      in_pc[d] = pc;
      out_ready[d] = orr;
      exp_rdy = (d == 0) ? (q.size() < 2) : (q.size() == 0 || orr);
      @(negedge clk);
      total++;
      if (out_valid[d] !== (q.size() > 0)) begin
        bad++;
        $display("[TB] FAIL stream_valid dut%0d cyc%0d: got %b want %b", d, cyc, out_valid[d], q.size() > 0);
      end
      if (q.size() > 0) begin
        total++;
        if (obs[d] !== q[0]) begin
          bad++;
          $display("[TB] FAIL stream_data dut%0d cyc%0d: got %h want %h", d, cyc, obs[d], q[0]);
        end
      end
      total++;
      if (in_ready[d] !== exp_rdy) begin
        bad++;
        $display("[TB] FAIL stream_in_ready dut%0d cyc%0d: got %b want %b", d, cyc, in_ready[d], exp_rdy);
      end
      @(posedge clk); #1;
      if (q.size() > 0 && orr) begin
        void'(q.pop_front());
        got++;
      end
      if (iv && exp_rdy) begin
        q.push_back(model(inst, pc, xlen));
        sent++;
      end
      cyc++;
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    total++;
    if (cyc >= 2000 || got != n) begin
      bad++;
      $display("[TB] FAIL stream_count dut%0d: got %0d words in %0d cycles want %0d", d, got, cyc, n);
    end
  endtask

  task automatic test_flush(input int d);
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_inst[d] = rand_inst();
      in_pc[d] = rand_pc();
      @(posedge clk); #1;
    end
    flush[d] = 1'b1;
    out_ready[d] = 1'b1;
    in_inst[d] = rand_inst();
    @(negedge clk);
    total++;
    if (out_valid[d] !== 1'b1 || in_ready[d] !== (d == 1)) begin
      bad++;
      $display("[TB] FAIL flush_before dut%0d: got valid=%b ready=%b want valid=1 ready=%b",
               d, out_valid[d], in_ready[d], d == 1);
    end
    @(posedge clk); #1;
    flush[d] = 1'b0;
    in_valid[d] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL flush_after dut%0d cyc%0d: got valid=%b ready=%b want valid=0 ready=1",
                 d, k, out_valid[d], in_ready[d]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1;
      out_ready[d] = 1'b0;
      in_inst[d] = 32'hFE21AC23;
      in_pc[d] = 64'hFFFF_FFFF_FFFF_FFF0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (out_valid[d] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL midreset_fill dut%0d: got %b want 1", d, out_valid[d]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (in_ready[d] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midreset_ready dut%0d: got %b want 0", d, in_ready[d]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || obs[d] !== '0) begin
        bad++;
        $display("[TB] FAIL midreset_state dut%0d: got valid=%b ready=%b data=%h want valid=0 ready=1 data=0",
                 d, out_valid[d], in_ready[d], obs[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_inst[d] = '0;
      in_pc[d] = '0;
      flush[d] = 1'b0;
      out_ready[d] = 1'b1;
    end
    test_reset();
    test_directed(0, 32'hFE000EE3, 64'h100, 64'hFFFF_FFFC, 3'd3, 1'b0);
    total++;
    if (obs[0].uses_rs1 !== 1'b1 || obs[0].uses_rs2 !== 1'b1 || obs[0].writes_rd !== 1'b0 || obs[0].pc !== 64'h100) begin
      bad++;
      $display("[TB] FAIL beq_flags: got rs1=%b rs2=%b rd=%b pc=%h want 1 1 0 100",
               obs[0].uses_rs1, obs[0].uses_rs2, obs[0].writes_rd, obs[0].pc);
    end
    test_directed(0, 32'h001000EF, 64'h104, 64'h0000_0800, 3'd5, 1'b0);
    test_directed(0, 32'hFE21AC23, 64'h108, 64'hFFFF_FFF8, 3'd2, 1'b0);
    test_directed(0, 32'h00000000, 64'h10C, 64'h0, 3'd1, 1'b1);
    test_directed(0, 32'h0000007F, 64'h110, 64'h0, 3'd1, 1'b1);
    test_directed(0, 32'h0000A063, 64'h114, 64'h0, 3'd3, 1'b1);
    test_directed(1, 32'h123452B7, 64'h8000_0000_0000_0100, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    test_directed(1, 32'h800002B7, 64'h8000_0000_0000_0104, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    test_directed(1, 32'hFE000EE3, 64'h108, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    test_stream(0, 0, 4);
    test_stream(1, 0, 4);
    test_stream(0, 1, 300);
    test_stream(1, 1, 300);
    test_flush(0);
    test_flush(1);
    test_mid_reset();
    test_stream(0, 1, 50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
